// File: rtl/block_scan_ctrl.sv
// block_scan_ctrl: steps an external averager over an N_COL x N_ROW grid of pixel blocks,
// one block per frame. Optional macro BLK_SCAN_SKIP_EN ignores one frame after every block.
module block_scan_ctrl #(
    parameter int H_BLK     = 64,
    parameter int V_BLK     = 64,
    parameter int N_COL     = 8,
    parameter int N_ROW     = 2,
    parameter int AVG_SHIFT = 6
) (
    input  logic       iODCK,
    input  logic       iRST,
    input  logic       iEn,
    input  logic       iVS,
    input  logic       iDE,
    input  logic [7:0] iPixelData,
    input  logic [7:0] iBlockData,
    output logic [7:0] oPixelData,
    output logic       oH_Duty,
    output logic       oV_Duty,
    output logic       oAvgRst_n,
    output logic [3:0] oSw_0Max_1Avg,
    output logic [7:0] oBlkIdx,
    output logic       oBlkValid,
    output logic [7:0] oBlkData,
    output logic       oAbort,
    output logic [2:0] oDbgState
);

    // oBlkValid is a one-clock strobe with no ready: oBlkIdx names the block while it is
    // high, oBlkData holds its result from the next clock; the consumer must take it then.
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_FRM = 3'd1;
    localparam logic [2:0] ACTIVE   = 3'd2;
    localparam logic [2:0] FOLD     = 3'd3;
    localparam logic [2:0] CAPTURE  = 3'd4;
    localparam logic [2:0] CLEAR    = 3'd5;

    logic [2:0]  state;
    logic [2:0]  nextState;
    logic        vsD;
    logic        deD;
    logic        vsRise;
    logic        deFall;
    logic [11:0] hcnt;
    logic [10:0] vcnt;
    logic [7:0]  colIdx;
    logic [7:0]  rowIdx;
    logic [7:0]  blkIdx;
    logic        lastQ;
    logic        capDone;
    logic [12:0] hLo;
    logic [12:0] hHi;
    logic [11:0] vLo;
    logic [11:0] vHi;
    logic        winHit;
    logic        lastHit;
    logic        abortNow;
    logic        stayActive;
`ifdef BLK_SCAN_SKIP_EN
    logic        skipPend;
`endif

    assign vsRise = iVS & ~vsD;
    assign deFall = ~iDE & deD;

    always_comb begin
        hLo = 13'(int'(colIdx) * H_BLK);
        hHi = 13'(int'(colIdx) * H_BLK + H_BLK);
        vLo = 12'(int'(rowIdx) * V_BLK);
        vHi = 12'(int'(rowIdx) * V_BLK + V_BLK);
    end

    assign winHit  = iDE && ({1'b0, hcnt} >= hLo) && ({1'b0, hcnt} < hHi)
                         && ({1'b0, vcnt} >= vLo) && ({1'b0, vcnt} < vHi);
    assign lastHit = winHit && (({1'b0, hcnt} + 13'd1) == hHi)
                            && (({1'b0, vcnt} + 12'd1) == vHi);

    always_comb begin
        nextState = state;
        abortNow  = 1'b0;
        case (state)
            IDLE:     if (iEn) nextState = WAIT_FRM;
            WAIT_FRM: begin
                if (!iEn) begin
                    nextState = IDLE;
                end else if (vsRise) begin
`ifdef BLK_SCAN_SKIP_EN
                    if (!skipPend) nextState = ACTIVE;
`else
                    nextState = ACTIVE;
`endif
                end
            end
            ACTIVE: begin
                // A new frame before the block completed means the averager saw a partial block.
                if (vsRise) begin
                    nextState = CLEAR;
                    abortNow  = 1'b1;
                end else if (!iEn) begin
                    nextState = CLEAR;
                end else if (lastQ) begin
                    nextState = FOLD;
                end
            end
            FOLD:     nextState = CAPTURE;
            CAPTURE:  nextState = CLEAR;
            CLEAR:    nextState = iEn ? WAIT_FRM : IDLE;
            default:  nextState = IDLE;
        endcase
    end

    assign stayActive = (state == ACTIVE) && (nextState == ACTIVE);

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            vsD  <= 1'b0;
            deD  <= 1'b0;
            hcnt <= 12'd0;
            vcnt <= 11'd0;
        end else begin
            vsD  <= iVS;
            deD  <= iDE;
            hcnt <= iDE ? hcnt + 12'd1 : 12'd0;
            if (vsRise) begin
                vcnt <= 11'd0;
            end else if (deFall) begin
                vcnt <= vcnt + 11'd1;
            end
        end
    end

    // Outputs are registered from nextState so each one is aligned with the state it marks.
    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            state      <= IDLE;
            oPixelData <= 8'd0;
            oH_Duty    <= 1'b0;
            lastQ      <= 1'b0;
            oV_Duty    <= 1'b0;
            oBlkValid  <= 1'b0;
            oAvgRst_n  <= 1'b0;
            oAbort     <= 1'b0;
        end else begin
            state      <= nextState;
            oPixelData <= iPixelData;
            oH_Duty    <= stayActive && winHit;
            lastQ      <= stayActive && lastHit;
            oV_Duty    <= (nextState == ACTIVE) || (nextState == FOLD);
            oBlkValid  <= (nextState == CAPTURE);
            oAvgRst_n  <= (nextState != CLEAR);
            oAbort     <= abortNow;
        end
    end

    // The index only moves on after a CLEAR that followed a real capture.
    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            oBlkData <= 8'd0;
            capDone  <= 1'b0;
            colIdx   <= 8'd0;
            rowIdx   <= 8'd0;
            blkIdx   <= 8'd0;
        end else begin
            if (state == CAPTURE) begin
                oBlkData <= iBlockData;
                capDone  <= 1'b1;
            end
            if (state == CLEAR) begin
                capDone <= 1'b0;
                if (capDone) begin
                    if (colIdx == 8'(N_COL - 1)) begin
                        colIdx <= 8'd0;
                        if (rowIdx == 8'(N_ROW - 1)) begin
                            rowIdx <= 8'd0;
                            blkIdx <= 8'd0;
                        end else begin
                            rowIdx <= rowIdx + 8'd1;
                            blkIdx <= blkIdx + 8'd1;
                        end
                    end else begin
                        colIdx <= colIdx + 8'd1;
                        blkIdx <= blkIdx + 8'd1;
                    end
                end
            end
        end
    end

`ifdef BLK_SCAN_SKIP_EN
    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            skipPend <= 1'b0;
        end else if (state == CLEAR) begin
            skipPend <= 1'b1;
        end else if ((state == WAIT_FRM) && vsRise) begin
            skipPend <= 1'b0;
        end
    end
`endif

    assign oBlkIdx       = blkIdx;
    assign oSw_0Max_1Avg = 4'(AVG_SHIFT);
    assign oDbgState     = state;

endmodule

// File: tb/tb_block_scan_ctrl.sv
// Bench for block_scan_ctrl on a 2x2 grid of 4x2 blocks over an 8x4 frame.
module tb_block_scan_ctrl;

    localparam int H_BLK    = 4;
    localparam int V_BLK    = 2;
    localparam int N_COL    = 2;
    localparam int N_ROW    = 2;
    localparam int LINE_PIX = 8;
    localparam logic [2:0] ST_IDLE = 3'd0;

    logic       clk = 1'b0;
    logic       rstN;
    logic       iEn;
    logic       iVS;
    logic       iDE;
    logic [7:0] iPixelData;
    logic [7:0] iBlockData;
    logic [7:0] oPixelData;
    logic       oH_Duty;
    logic       oV_Duty;
    logic       oAvgRst_n;
    logic [3:0] oSw_0Max_1Avg;
    logic [7:0] oBlkIdx;
    logic       oBlkValid;
    logic [7:0] oBlkData;
    logic       oAbort;
    logic [2:0] oDbgState;

    block_scan_ctrl #(
        .H_BLK(H_BLK), .V_BLK(V_BLK), .N_COL(N_COL), .N_ROW(N_ROW), .AVG_SHIFT(6)
    ) dut (
        .iODCK(clk), .iRST(rstN), .iEn(iEn), .iVS(iVS), .iDE(iDE),
        .iPixelData(iPixelData), .iBlockData(iBlockData),
        .oPixelData(oPixelData), .oH_Duty(oH_Duty), .oV_Duty(oV_Duty),
        .oAvgRst_n(oAvgRst_n), .oSw_0Max_1Avg(oSw_0Max_1Avg), .oBlkIdx(oBlkIdx),
        .oBlkValid(oBlkValid), .oBlkData(oBlkData), .oAbort(oAbort), .oDbgState(oDbgState)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         nValid;
    int         nAbort;
    int         validCyc;
    int         rstLowCyc;
    int         lastDutyCyc;
    int         vDutyBad;
    int         capCyc;
    logic [7:0] validIdx;
    logic [7:0] dataSeen;
    logic [7:0] lastCode;
    logic [7:0] blkVal;
    int         nErr = 0;
    int         nChecks = 0;

    typedef struct {
        logic       en;
        logic [7:0] data;
        int         ctl;       // 0 full frame, 1 early VS after ctlLine lines, 2 drop iEn after ctlLine lines
        int         ctlLine;
        int         expValid;
        int         expAbort;
        logic [7:0] expIdx;
    } frame_t;

    frame_t tbl[11];
    frame_t afterReset;

    always @(negedge clk) begin
        if (rstN) begin
            if (oH_Duty) begin
                got_q.push_back(oPixelData);
                lastDutyCyc = cyc;
                if (!oV_Duty) vDutyBad++;
            end
            if (oBlkValid) begin
                nValid++;
                validCyc = cyc;
                validIdx = oBlkIdx;
            end
            if (!oAvgRst_n) rstLowCyc = cyc;
            if (oAbort) nAbort++;
            if (cyc == validCyc + 1) dataSeen = oBlkData;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic step(input logic vs, input logic de, input logic [7:0] pix);
        iVS        = vs;
        iDE        = de;
        iPixelData = pix;
        iBlockData = (cyc == capCyc) ? blkVal : ~blkVal;
        if (de && pix == lastCode) capCyc = cyc + 3;
        @(posedge clk);
        #1;
    endtask

    task automatic runLines(input int first, input int last);
        for (int l = first; l <= last; l++) begin
            for (int p = 0; p < LINE_PIX; p++) step(1'b0, 1'b1, 8'(l * 16 + p));
            for (int p = 0; p < 4; p++) step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic frameHead();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frameTail();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clearSb();
        got_q.delete();
        exp_q.delete();
        nValid      = 0;
        nAbort      = 0;
        vDutyBad    = 0;
        rstLowCyc   = -1;
        lastDutyCyc = -1;
        validCyc    = -10;
        capCyc      = -10;
        dataSeen    = 8'h00;
        validIdx    = 8'h00;
    endtask

    task automatic resetChecks(input string tag);
        check({tag, "_hduty"}, 32'(oH_Duty), 32'd0);
        check({tag, "_vduty"}, 32'(oV_Duty), 32'd0);
        check({tag, "_avgrst"}, 32'(oAvgRst_n), 32'd0);
        check({tag, "_valid"}, 32'(oBlkValid), 32'd0);
        check({tag, "_abort"}, 32'(oAbort), 32'd0);
        check({tag, "_blkdata"}, 32'(oBlkData), 32'd0);
        check({tag, "_pixdata"}, 32'(oPixelData), 32'd0);
        check({tag, "_blkidx"}, 32'(oBlkIdx), 32'd0);
        check({tag, "_state"}, 32'(oDbgState), 32'(ST_IDLE));
    endtask

    task automatic runFrame(input frame_t f, input int k);
        int row;
        int col;
        row = int'(f.expIdx) / N_COL;
        col = int'(f.expIdx) % N_COL;
        clearSb();
        blkVal = f.data;
        iEn    = f.en;
        if (f.expValid != 0) begin
            lastCode = 8'(((row + 1) * V_BLK - 1) * 16 + (col + 1) * H_BLK - 1);
            for (int l = row * V_BLK; l < (row + 1) * V_BLK; l++)
                for (int p = col * H_BLK; p < (col + 1) * H_BLK; p++)
                    exp_q.push_back(8'(l * 16 + p));
        end else begin
            lastCode = 8'hFF;
        end
        frameHead();
        case (f.ctl)
            1: begin
                runLines(0, f.ctlLine - 1);
                step(1'b1, 1'b0, 8'h00);
                step(1'b1, 1'b0, 8'h00);
            end
            2: begin
                runLines(0, f.ctlLine - 1);
                iEn = 1'b0;
                runLines(f.ctlLine, 3);
            end
            default: runLines(0, 3);
        endcase
        frameTail();
        check($sformatf("f%0d_nvalid", k), 32'(nValid), 32'(f.expValid));
        check($sformatf("f%0d_nabort", k), 32'(nAbort), 32'(f.expAbort));
        if (f.expValid != 0) begin
            check($sformatf("f%0d_idx", k), 32'(validIdx), 32'(f.expIdx));
            check($sformatf("f%0d_last_duty_cyc", k), 32'(lastDutyCyc), 32'(capCyc - 2));
            check($sformatf("f%0d_valid_cyc", k), 32'(validCyc), 32'(capCyc));
            check($sformatf("f%0d_avgrst_cyc", k), 32'(rstLowCyc), 32'(capCyc + 1));
            check($sformatf("f%0d_blkdata", k), 32'(dataSeen), 32'(f.data));
            check($sformatf("f%0d_duty_count", k), 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("f%0d_duty_pix%0d", k, i), 32'(got_q[i]), 32'(exp_q[i]));
            check($sformatf("f%0d_vduty_in_window", k), 32'(vDutyBad), 32'd0);
            check($sformatf("f%0d_vduty_end", k), 32'(oV_Duty), 32'd0);
            check($sformatf("f%0d_avgrst_end", k), 32'(oAvgRst_n), 32'd1);
        end
        if (f.ctl == 2) check($sformatf("f%0d_state_idle", k), 32'(oDbgState), 32'(ST_IDLE));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h5A, 0, 0, 1, 0, 8'd0};
        tbl[1]  = '{1'b1, 8'h3C, 0, 0, 1, 0, 8'd1};
        tbl[2]  = '{1'b1, 8'hA5, 0, 0, 1, 0, 8'd2};
        tbl[3]  = '{1'b1, 8'h0F, 0, 0, 1, 0, 8'd3};
        tbl[4]  = '{1'b1, 8'h96, 0, 0, 1, 0, 8'd0};
        tbl[5]  = '{1'b1, 8'h11, 0, 0, 1, 0, 8'd1};
        tbl[6]  = '{1'b1, 8'h77, 1, 1, 0, 1, 8'd2};
        tbl[7]  = '{1'b1, 8'h22, 0, 0, 1, 0, 8'd2};
        tbl[8]  = '{1'b1, 8'h44, 2, 3, 0, 0, 8'd3};
        tbl[9]  = '{1'b1, 8'h33, 0, 0, 1, 0, 8'd3};
        tbl[10] = '{1'b1, 8'hC3, 0, 0, 1, 0, 8'd0};
        afterReset = '{1'b1, 8'h6B, 0, 0, 1, 0, 8'd0};

        rstN       = 1'b0;
        iEn        = 1'b0;
        iVS        = 1'b0;
        iDE        = 1'b0;
        iPixelData = 8'hAB;
        iBlockData = 8'hCD;
        clearSb();
        lastCode   = 8'hFF;
        blkVal     = 8'h00;
        repeat (3) @(negedge clk);
        resetChecks("rst0");
        check("sw_avg_shift", 32'(oSw_0Max_1Avg), 32'd6);

        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        check("post_rst_avgrst", 32'(oAvgRst_n), 32'd1);
        check("post_rst_idle", 32'(oDbgState), 32'(ST_IDLE));

        for (int k = 0; k < 11; k++) runFrame(tbl[k], k);

        // reset asserted while measuring block 1
        clearSb();
        blkVal   = 8'hEE;
        lastCode = 8'hFF;
        iEn      = 1'b1;
        frameHead();
        runLines(0, 0);
        step(1'b0, 1'b1, 8'h24);
        check("pre_rst_idx", 32'(oBlkIdx), 32'd1);
        rstN = 1'b0;
        step(1'b0, 1'b1, 8'h25);
        step(1'b0, 1'b1, 8'h26);
        @(negedge clk);
        resetChecks("rst_mid");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        runLines(2, 3);
        frameTail();
        check("rst_mid_nvalid", 32'(nValid), 32'd0);
        check("rst_mid_nabort", 32'(nAbort), 32'd0);
        check("rst_mid_idx", 32'(oBlkIdx), 32'd0);
        runFrame(afterReset, 11);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule

// File: doc/block_scan_ctrl.md
BLOCK_SCAN_CTRL -- requirements
Module: block_scan_ctrl

Interface
REQ-001 The block SHALL have parameter H_BLK, default 64, meaning active pixels per block column.
REQ-002 The block SHALL have parameter V_BLK, default 64, meaning active lines per block row.
REQ-003 The block SHALL have parameter N_COL, default 8, meaning block columns per frame.
REQ-004 The block SHALL have parameter N_ROW, default 2, meaning block rows per frame.
REQ-005 The block SHALL have parameter AVG_SHIFT, default 6, meaning the constant driven on oSw_0Max_1Avg.
REQ-006 The block SHALL have port iODCK, input, 1 bit, pixel clock; all state changes on its rising edge.
REQ-007 The block SHALL have port iRST, input, 1 bit, reset: asynchronous, active-low.
REQ-008 The block SHALL have port iEn, input, 1 bit, scan enable.
REQ-009 The block SHALL have port iVS, input, 1 bit, vertical sync, active-high; its rising edge marks frame start.
REQ-010 The block SHALL have port iDE, input, 1 bit, data enable, high during active pixels.
REQ-011 The block SHALL have port iPixelData, input, 8 bits, raw pixel.
REQ-012 The block SHALL have port iBlockData, input, 8 bits, result returned by the averager.
REQ-013 The block SHALL have port oPixelData, output, 8 bits, iPixelData delayed 1 clock.
REQ-014 The block SHALL have port oH_Duty, output, 1 bit, averager pixel window.
REQ-015 The block SHALL have port oV_Duty, output, 1 bit, averager line window.
REQ-016 The block SHALL have port oAvgRst_n, output, 1 bit, averager clear, active-low.
REQ-017 The block SHALL have port oSw_0Max_1Avg, output, 4 bits, equal to AVG_SHIFT[3:0].
REQ-018 The block SHALL have port oBlkIdx, output, 8 bits, index of the block being measured or just captured (row*N_COL + col).
REQ-019 The block SHALL have port oBlkValid, output, 1 bit, one-clock pulse when a block result is ready.
REQ-020 The block SHALL have port oBlkData, output, 8 bits, captured block result.
REQ-021 The block SHALL have port oAbort, output, 1 bit, one-clock pulse when a measurement is abandoned.

Function
REQ-022 The block SHALL maintain a 12-bit hcnt counting iDE-high cycles within a line, cleared on every iDE-low cycle.
REQ-023 The block SHALL maintain an 11-bit vcnt incremented on each iDE falling edge, cleared on iVS rising edge.
REQ-024 The block SHALL implement the states IDLE, WAIT_FRM, ACTIVE, FOLD, CAPTURE and CLEAR.
REQ-025 In IDLE, the block SHALL go to WAIT_FRM when iEn=1.
REQ-026 In WAIT_FRM, the block SHALL go to ACTIVE on iVS rising edge.
REQ-027 In ACTIVE, the block SHALL register oH_Duty=1 for exactly one clock per pixel when iDE=1, col*H_BLK <= hcnt < (col+1)*H_BLK and row*V_BLK <= vcnt < (row+1)*V_BLK; otherwise oH_Duty=0.
REQ-028 oV_Duty SHALL be 1 in ACTIVE and FOLD and 0 in all other states.
REQ-029 The cycle after oH_Duty is high for the final pixel (hcnt=(col+1)*H_BLK-1, vcnt=(row+1)*V_BLK-1), the block SHALL enter FOLD with oH_Duty=0 for one clock.
REQ-030 From FOLD, the block SHALL go to CAPTURE; in CAPTURE it SHALL assert oBlkValid=1 and register iBlockData into oBlkData at the end of that clock.
REQ-031 From CAPTURE, the block SHALL go to CLEAR; in CLEAR it SHALL drive oAvgRst_n=0 for one clock, advance the block index, and go to WAIT_FRM if iEn=1, else to IDLE.
REQ-032 Latency: the final in-block pixel has oH_Duty high at cycle t; oBlkValid SHALL be high at t+2 and oAvgRst_n low at t+3.
REQ-033 The block index SHALL advance column-first and wrap from N_COL*N_ROW-1 to 0 with row 0, column 0.
REQ-034 An iVS rising edge while in ACTIVE SHALL send the block to CLEAR with oAbort=1 for that clock, no oBlkValid, and no index advance.
REQ-035 When iEn falls while in ACTIVE, the block SHALL go to CLEAR without oBlkValid or index advance, then to IDLE.
REQ-036 In FOLD and CAPTURE, an iVS edge or iEn change SHALL be ignored until CLEAR.
REQ-037 oPixelData SHALL be iPixelData registered, so that it is aligned with oH_Duty.

Reset
REQ-038 While iRST=0, the state SHALL be IDLE, hcnt=0, vcnt=0, block index=0, oH_Duty=0, oV_Duty=0, oAvgRst_n=0, oBlkValid=0, oAbort=0, oBlkData=0, oPixelData=0.
REQ-039 After iRST releases, oAvgRst_n SHALL be 1 except in CLEAR; reset asserted mid-ACTIVE SHALL discard the measurement with no pulse.

Configuration
REQ-040 With macro BLK_SCAN_SKIP_EN defined, after each CLEAR the block SHALL ignore one full frame (one extra iVS rising edge) before entering ACTIVE.
REQ-041 Without BLK_SCAN_SKIP_EN, ACTIVE SHALL be entered on the next iVS rising edge after CLEAR.

Verification
REQ-042 Config H_BLK=4, V_BLK=2, N_COL=2, N_ROW=2, 8x4 frame, block 0 -> oH_Duty high for hcnt 0..3 on lines 0..1, oBlkValid 2 clocks after the last window pixel, oBlkIdx=0.
REQ-043 Same config, iBlockData=0x5A during CAPTURE -> oBlkData=0x5A the next clock, oAvgRst_n low one clock later.
REQ-044 Five consecutive frames -> oBlkIdx sequence 0,1,2,3,0.
REQ-045 iVS rising edge at vcnt=1 during block 2 -> oAbort pulse, no oBlkValid, next frame measures block 2 again.
REQ-046 iRST low during ACTIVE -> all outputs at reset values, oBlkIdx=0, no oBlkValid after release until a full block completes.
REQ-047 BLK_SCAN_SKIP_EN defined -> oBlkValid occurs on every second frame only.
